// File: rtl/apb4_regfile_slave_pkg.sv
// Shared types and sizing helpers for the APB4 register-file completer.
// Holds the transfer FSM encoding plus the byte-lane and index width helpers.
package apb4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int WAIT_CNT_W = 4;

    function automatic int BYTES(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int IDX_W(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/apb4_regfile_slave_if.sv
// APB4 bus bundle (with pstrb) shared by the completer and its requester.
// The requester drives the select/control/data signals; the completer returns prdata/pready/pslverr.
interface apb4_regfile_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb4_regfile_slave_wait_ctrl.sv
// Transfer FSM and wait counter: pready (registered) rises WAIT_STATES+1 cycles after SETUP.
// complete_o is the next-edge view of pready, so the datapath commits on the same edge pready rises.
module apb4_wait_ctrl
    import apb4_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic psel_i,
    input  logic penable_i,
    output logic setup_o,
    output logic pready_o,
    output logic complete_o
);

    apb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  pready_q, pready_d;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        setup_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // penable=1 without a preceding setup phase is not a transfer start
                if (psel_i && !penable_i) begin
                    state_d    = SETUP;
                    wait_cnt_d = WAIT_CNT_W'(WAIT_STATES);
                    setup_o    = 1'b1;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (pready_q) begin
                    state_d = IDLE;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        pready_d = (state_d == ACCESS) && (wait_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            pready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pready_q   <= pready_d;
        end
    end

    assign pready_o   = pready_q;
    assign complete_o = pready_d;

endmodule

// File: rtl/apb4_regfile_slave.sv
// APB4 completer over NUM_REGS registers with byte strobes, RO mask and error response.
// Response registered; completes WAIT_STATES+1 cycles after SETUP; bus stalled via pready meanwhile.
module apb4_regfile_slave
    import apb4_pkg::*;
#(
    parameter int                  ADDR_W      = 32,
    parameter int                  DATA_W      = 32,
    parameter int                  NUM_REGS    = 16,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    apb4_regfile_slave_if.slave          apb,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int                NB       = BYTES(DATA_W);
    localparam int                IW       = IDX_W(NUM_REGS);
    localparam int                OFF_W    = $clog2(NB);
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(NUM_REGS * NB);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NB - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [NB-1:0]     strb;
    } req_t;

    req_t                              req_q, req_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
    logic [DATA_W-1:0]                 prdata_q, prdata_d;
    logic                              pslverr_q, pslverr_d;
    logic [NUM_REGS-1:0]               wr_pulse_q, wr_pulse_d;

    logic          setup;
    logic          complete;
    logic [IW-1:0] idx;
    logic          err;

    apb4_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .clk        (clk),
        .rst        (rst),
        .psel_i     (apb.psel),
        .penable_i  (apb.penable),
        .setup_o    (setup),
        .pready_o   (apb.pready),
        .complete_o (complete)
    );

    // Decode runs off the latched request so bus changes after SETUP have no effect
    assign idx = req_q.addr[OFF_W +: IW];
    assign err = (req_q.addr >= SPAN)
              || ((req_q.addr & OFF_MASK) != '0)
              || (req_q.write && RO_MASK[idx]);

    always_comb begin
        req_d      = req_q;
        regs_d     = regs_q;
        prdata_d   = prdata_q;
        pslverr_d  = 1'b0;
        wr_pulse_d = '0;
        if (setup) begin
            req_d.addr  = apb.paddr;
            req_d.write = apb.pwrite;
            req_d.wdata = apb.pwdata;
            req_d.strb  = apb.pstrb;
        end
        if (complete) begin
            pslverr_d = err;
            if (req_q.write) begin
                if (!err) begin
                    for (int b = 0; b < NB; b++) begin
                        if (req_q.strb[b]) begin
                            regs_d[idx][b*8 +: 8] = req_q.wdata[b*8 +: 8];
                        end
                    end
                    wr_pulse_d[idx] = 1'b1;
                end
            end else begin
                prdata_d = err ? '0 : regs_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            regs_q     <= '0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            wr_pulse_q <= '0;
        end else begin
            req_q      <= req_d;
            regs_q     <= regs_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
    assign regs_o      = regs_q;
    assign wr_pulse_o  = wr_pulse_q;

endmodule

// File: tb/tb_apb4_regfile_slave.sv
// Scoreboard bench: three completers (0, 3 and 5 wait states) share one driven APB bus.
// The driver queues the expected response per transfer; a negedge monitor checks each pready.
module tb_apb4_regfile_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    int          sel;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          exp_cyc;
        logic        is_read;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [15:0] exp_pulse;
    } exp_t;

    exp_t sb_q[$];

    apb4_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    apb4_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
    apb4_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) if2 ();

    logic [511:0] regs0, regs1, regs2;
    logic [15:0]  pulse0, pulse1, pulse2;

    assign if0.psel = psel && (sel == 0);
    assign if1.psel = psel && (sel == 1);
    assign if2.psel = psel && (sel == 2);
    assign {if0.penable, if0.pwrite, if0.paddr, if0.pwdata, if0.pstrb} = {penable, pwrite, paddr, pwdata, pstrb};
    assign {if1.penable, if1.pwrite, if1.paddr, if1.pwdata, if1.pstrb} = {penable, pwrite, paddr, pwdata, pstrb};
    assign {if2.penable, if2.pwrite, if2.paddr, if2.pwdata, if2.pstrb} = {penable, pwrite, paddr, pwdata, pstrb};

    apb4_regfile_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(0), .RO_MASK(16'h0001))
        dut0 (.clk(clk), .rst(rst), .apb(if0), .regs_o(regs0), .wr_pulse_o(pulse0));
    apb4_regfile_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(3), .RO_MASK(16'h0000))
        dut1 (.clk(clk), .rst(rst), .apb(if1), .regs_o(regs1), .wr_pulse_o(pulse1));
    apb4_regfile_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .WAIT_STATES(5), .RO_MASK(16'h0000))
        dut2 (.clk(clk), .rst(rst), .apb(if2), .regs_o(regs2), .wr_pulse_o(pulse2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic         cur_pready, cur_pslverr;
    logic [31:0]  cur_prdata;
    logic [511:0] cur_regs;
    logic [15:0]  cur_pulse;

    always_comb begin
        case (sel)
            1: begin
                cur_pready = if1.pready; cur_pslverr = if1.pslverr; cur_prdata = if1.prdata;
                cur_regs = regs1; cur_pulse = pulse1;
            end
            2: begin
                cur_pready = if2.pready; cur_pslverr = if2.pslverr; cur_prdata = if2.prdata;
                cur_regs = regs2; cur_pulse = pulse2;
            end
            default: begin
                cur_pready = if0.pready; cur_pslverr = if0.pslverr; cur_prdata = if0.prdata;
                cur_regs = regs0; cur_pulse = pulse0;
            end
        endcase
    end

    function automatic int wait_of(input int d);
        return (d == 1) ? 3 : (d == 2) ? 5 : 0;
    endfunction

    function automatic logic [31:0] reg_of(input int i);
        return cur_regs[i*32 +: 32];
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d cyc=%0d got=%0h expected=%0h", nm, sel, cyc, act, exp);
        end
    endtask

    // Monitor: every pready must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (cur_pready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pready", 512'(cur_pready), 512'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("completion_cycle", 512'(cyc), 512'(e.exp_cyc));
                    chk("pslverr", 512'(cur_pslverr), 512'(e.exp_err));
                    chk("wr_pulse", 512'(cur_pulse), 512'(e.exp_pulse));
                    if (e.is_read) chk("prdata", 512'(cur_prdata), 512'(e.exp_rdata));
                end
            end else if (cur_pulse != '0) begin
                chk("stray_wr_pulse", 512'(cur_pulse), 512'(0));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after completion with the bus idle
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [15:0] exp_pulse, input bit mangle);
        exp_t e;
        int   n;
        sel = d;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        e.exp_cyc   = cyc + 2 + wait_of(d);
        e.is_read   = !wr;
        e.exp_err   = exp_err;
        e.exp_rdata = exp_rdata;
        e.exp_pulse = exp_pulse;
        sb_q.push_back(e);
        @(posedge clk); #1;
        penable = 1'b1;
        if (mangle) begin
            psel = 1'b0; pwrite = !wr; paddr = addr ^ 32'h8; pwdata = ~wdata; pstrb = ~strb;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cur_pready && n < 40);
        if (!cur_pready) chk("pready_timeout", 512'(n), 512'(wait_of(d) + 2));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            sel = d; #1;
            chk("reset_regs", cur_regs, 512'(0));
            chk("reset_pready", 512'(cur_pready), 512'(0));
            chk("reset_pslverr", 512'(cur_pslverr), 512'(0));
            chk("reset_prdata", 512'(cur_prdata), 512'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero wait states, back-to-back write then read
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 16'h0002, 1'b0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 16'h0000, 1'b0);
        chk("reg1_written", 512'(reg_of(1)), 512'(32'hDEADBEEF));

        // Byte strobes
        xfer(0, 1'b1, 32'h08, 32'h11223344, 4'hF, 1'b0, 32'h0, 16'h0004, 1'b0);
        xfer(0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 16'h0004, 1'b0);
        chk("reg2_strobed", 512'(reg_of(2)), 512'(32'h11BB33DD));
        xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, 32'h11BB33DD, 16'h0000, 1'b0);

        // pstrb=0 is a pulsing no-op
        xfer(0, 1'b1, 32'h0C, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, 16'h0008, 1'b0);
        xfer(0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, 16'h0008, 1'b0);
        chk("reg3_strb0", 512'(reg_of(3)), 512'(32'hA5A5A5A5));

        // Errors: out of range, misaligned, read-only
        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h0, 16'h0000, 1'b0);
        xfer(0, 1'b1, 32'h06, 32'h12345678, 4'hF, 1'b1, 32'h0, 16'h0000, 1'b0);
        xfer(0, 1'b1, 32'h00, 32'h87654321, 4'hF, 1'b1, 32'h0, 16'h0000, 1'b0);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 16'h0000, 1'b0);
        xfer(0, 1'b0, 32'h06, 32'h0, 4'h0, 1'b1, 32'h0, 16'h0000, 1'b0);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, 32'h0, 16'h0000, 1'b0);
        chk("reg0_ro_kept", 512'(reg_of(0)), 512'(0));
        chk("reg1_after_errs", 512'(reg_of(1)), 512'(32'hDEADBEEF));

        // Bus changes after SETUP are ignored
        xfer(0, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b0, 32'h0, 16'h0010, 1'b1);
        chk("reg4_latched", 512'(reg_of(4)), 512'(32'h12345678));
        chk("reg6_untouched", 512'(reg_of(6)), 512'(0));

        // penable=1 in IDLE does not start a transfer
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hFFFF0000; pstrb = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reg5_no_start", 512'(reg_of(5)), 512'(0));

        // Three wait states
        xfer(1, 1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 16'h8000, 1'b0);
        xfer(1, 1'b0, 32'h3C, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 16'h0000, 1'b0);
        xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h0, 16'h0000, 1'b0);

        // Reset two wait cycles into a five-wait-state write
        sel = 2;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h55AA55AA; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_no_commit", 512'(reg_of(1)), 512'(0));
        chk("rst_mid_pulse", 512'(cur_pulse), 512'(0));
        chk("rst_mid_pready", 512'(cur_pready), 512'(0));
        rst = 1'b0;
        xfer(2, 1'b1, 32'h04, 32'h55AA55AA, 4'hF, 1'b0, 32'h0, 16'h0002, 1'b0);
        xfer(2, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, 32'h55AA55AA, 16'h0000, 1'b0);
        chk("reg1_after_rst", 512'(reg_of(1)), 512'(32'h55AA55AA));

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 512'(sb_q.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

endmodule
